ff_pipe_bank: RTL

FF_PIPE_BANK -- requirements
Module: ff_pipe_bank

---
 rtl/ff_pipe_bank.sv | 89 ++++++++
 1 files changed

// File: rtl/ff_pipe_bank.sv
// Parameterised bank of valid-qualified register stages with an optional
// combinational bypass and a saturating toggle counter on the last stage.
module ff_pipe_bank #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CK,
  input  logic             RSTB,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_IN,
  input  logic             BYPASS,
  input  logic             TGL_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_OUT,
  output logic [CNT_W-1:0] TGL_CNT
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "ff_pipe_bank: WIDTH=%0d outside 1..64", WIDTH);
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $fatal(1, "ff_pipe_bank: DEPTH=%0d outside 1..8", DEPTH);
  end
  if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
    $fatal(1, "ff_pipe_bank: CNT_W=%0d outside 8..32", CNT_W);
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] flips;
  logic [CNT_W:0]   ones;
  logic [CNT_W:0]   sum;

  // Stage 0 zeroes its data on a bubble so invalid slots carry no stale bits.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (EN) begin
      data_d[0] = VLD_IN ? D : '0;
      vld_d[0]  = VLD_IN;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end

  // Toggle count compares the last stage before and after this edge; the
  // extra sum bit flags overflow so the counter clamps instead of wrapping.
  always_comb begin
    flips = data_q[DEPTH-1] ^ data_d[DEPTH-1];
    ones  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{CNT_W{1'b0}}, flips[i]};
    end
    sum   = {1'b0, cnt_q} + ones;
    cnt_d = cnt_q;
    if (TGL_CLR) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTB) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q       = BYPASS ? D : data_q[DEPTH-1];
  assign VLD_OUT = BYPASS ? VLD_IN : vld_q[DEPTH-1];
  assign TGL_CNT = cnt_q;

endmodule
